// File: rtl/hawk_att_lookup.sv
// ATT lookup stage: maps a host page number to its ATT line, fetches it over AXI
// (or reuses the last fetched line) and decodes the 8-byte entry into a translation packet.
module hawk_att_lookup #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 512,
  parameter int LEN_WIDTH     = 8,
  parameter int RESP_WIDTH    = 2,
  parameter logic [ADDR_WIDTH-1:0] ATT_START = 64'hFFF6100000,
  parameter logic [ADDR_WIDTH-1:0] HPPA_BASE = 64'hFFF6400000,
  parameter int ATT_ENTRY_MAX = 524288,
  parameter int BYTESWAP      = 1,
  parameter int LINE_BUF_EN   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lkup_valid_i,
  output logic                  lkup_ready_o,
  input  logic [ADDR_WIDTH-13:0] lkup_hppa_i,
  input  logic                  lkup_zeroblkwr_i,
  input  logic                  att_inval_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [LEN_WIDTH-1:0]  arlen_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [RESP_WIDTH-1:0] rresp_i,
  input  logic                  rlast_i,
  output logic                  trnsl_valid_o,
  input  logic                  trnsl_ready_i,
  output logic [ADDR_WIDTH-1:0] trnsl_ppa_o,
  output logic [1:0]            trnsl_sts_o,
  output logic [7:0]            trnsl_zpd_cnt_o,
  output logic                  trnsl_zpd_update_o,
  output logic                  trnsl_allow_access_o,
  output logic                  trnsl_err_o
);

  localparam int HPPA_W = ADDR_WIDTH - 12;
  localparam int IDX_W  = $clog2(ATT_ENTRY_MAX);
  localparam int TAG_W  = IDX_W - 3;
  localparam int LANES  = DATA_WIDTH / 64;
  localparam logic [HPPA_W-1:0] BASE_PG   = HPPA_BASE[ADDR_WIDTH-1:12];
  localparam logic [HPPA_W-1:0] ENTRY_MAX = HPPA_W'(ATT_ENTRY_MAX);
  localparam logic [1:0] STS_DALLOC = 2'b00;
  localparam logic [1:0] STS_UNCOMP = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]            r_slot;
  logic                  r_zbw;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_buf_vld;
  logic [TAG_W-1:0]      r_buf_tag;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic [ADDR_WIDTH-1:0] r_ppa;
  logic [1:0]            r_sts;
  logic [7:0]            r_zpd;
  logic                  r_upd, r_allow, r_err;

  logic [HPPA_W-1:0]     w_diff;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_oor, w_hit, w_accept, w_load, w_fill, w_in_idle, w_bad, w_zbw, w_upd;
  logic [2:0]            w_slot;
  logic [DATA_WIDTH-1:0] w_raw, w_line;
  logic [63:0]           w_entry;
  logic [7:0]            w_zpd;
  logic                  w_unused_bits;

  assign w_diff    = lkup_hppa_i - BASE_PG;
  assign w_oor     = (lkup_hppa_i < BASE_PG) || (w_diff >= ENTRY_MAX);
  assign w_tag     = w_diff[IDX_W-1:3];
  assign w_in_idle = (r_state == S_IDLE);
  assign w_accept  = lkup_valid_i && w_in_idle;
  assign w_hit     = (LINE_BUF_EN != 0) && r_buf_vld && (r_buf_tag == w_tag) && !att_inval_i;
  assign w_fill    = (r_state == S_R) && rvalid_i && (rresp_i == '0) && rlast_i;
  assign w_load    = (w_accept && (w_oor || w_hit)) || ((r_state == S_R) && rvalid_i);

  // Decode from the buffer in the accept cycle (hit) or from the bus on the data beat.
  assign w_raw  = w_in_idle ? r_buf_data : rdata_i;
  assign w_slot = w_in_idle ? w_diff[2:0] : r_slot;
  assign w_zbw  = w_in_idle ? lkup_zeroblkwr_i : r_zbw;
  assign w_bad  = w_in_idle ? w_oor : ((rresp_i != '0) || !rlast_i);

  always_comb begin
    w_line = w_raw;
    if (BYTESWAP != 0) begin
      for (int l = 0; l < LANES; l++) begin
        for (int b = 0; b < 8; b++) begin
          w_line[64*l + 8*b +: 8] = w_raw[64*l + 8*(7-b) +: 8];
        end
      end
    end
  end

  assign w_entry       = w_line[{w_slot, 6'b000} +: 64];
  assign w_zpd         = w_entry[63:56];
  assign w_upd         = w_zbw && (w_entry[1:0] == STS_UNCOMP);
  assign w_unused_bits = ^w_entry[55:ADDR_WIDTH-10];

  always_comb begin
    w_next               = r_state;
    lkup_ready_o         = 1'b0;
    arvalid_o            = 1'b0;
    rready_o             = 1'b0;
    trnsl_valid_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        lkup_ready_o = 1'b1;
        if (w_accept) w_next = (w_oor || w_hit) ? S_RESP : S_AR;
      end
      S_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) w_next = S_R;
      end
      S_R: begin
        rready_o = 1'b1;
        if (rvalid_i) w_next = S_RESP;
      end
      S_RESP: begin
        trnsl_valid_o = 1'b1;
        if (trnsl_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_araddr  <= '0;
      r_slot    <= '0;
      r_zbw     <= 1'b0;
      r_tag     <= '0;
      r_buf_vld <= 1'b0;
      r_buf_tag <= '0;
      r_ppa     <= '0;
      r_sts     <= '0;
      r_zpd     <= '0;
      r_upd     <= 1'b0;
      r_allow   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_slot   <= w_diff[2:0];
        r_zbw    <= lkup_zeroblkwr_i;
        r_tag    <= w_tag;
        r_araddr <= ATT_START + {{(ADDR_WIDTH-TAG_W-6){1'b0}}, w_tag, 6'b000000};
      end
      if (w_load) begin
        if (w_bad) begin
          r_err   <= 1'b1;
          r_allow <= 1'b0;
          r_sts   <= STS_DALLOC;
          r_ppa   <= '0;
          r_upd   <= 1'b0;
          r_zpd   <= '0;
        end else begin
          r_err   <= 1'b0;
          r_allow <= (w_entry[1:0] == STS_UNCOMP);
          r_sts   <= w_entry[1:0];
          r_ppa   <= {w_entry[ADDR_WIDTH-11:2], 12'h000};
          r_upd   <= w_upd;
          r_zpd   <= (w_upd && (w_zpd != 8'hFF)) ? w_zpd + 8'd1 : w_zpd;
        end
      end
      // Invalidation beats a same-cycle fill so a stale line is never retained.
      if (att_inval_i) r_buf_vld <= 1'b0;
      else if (w_fill) r_buf_vld <= 1'b1;
      if (w_fill) r_buf_tag <= r_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill) r_buf_data <= rdata_i;
  end

  assign araddr_o             = r_araddr;
  assign arlen_o              = '0;
  assign trnsl_ppa_o          = r_ppa;
  assign trnsl_sts_o          = r_sts;
  assign trnsl_zpd_cnt_o      = r_zpd;
  assign trnsl_zpd_update_o   = r_upd;
  assign trnsl_allow_access_o = r_allow;
  assign trnsl_err_o          = r_err;

endmodule

// File: tb/tb_hawk_att_lookup.sv
// Directed bench for hawk_att_lookup: miss/hit/invalidate, zpd decode, errors, range and backpressure.
module tb_hawk_att_lookup;

  localparam logic [51:0] BASE  = 52'hFFF6400;
  localparam logic [63:0] ATT_S = 64'hFFF6100000;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         lkup_valid_i = 1'b0;
  logic         lkup_ready_o;
  logic [51:0]  lkup_hppa_i = '0;
  logic         lkup_zeroblkwr_i = 1'b0;
  logic         att_inval_i = 1'b0;
  logic         arvalid_o;
  logic         arready_i = 1'b0;
  logic [63:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic         rvalid_i = 1'b0;
  logic         rready_o;
  logic [511:0] rdata_i = '0;
  logic [1:0]   rresp_i = '0;
  logic         rlast_i = 1'b0;
  logic         trnsl_valid_o;
  logic         trnsl_ready_i = 1'b0;
  logic [63:0]  trnsl_ppa_o;
  logic [1:0]   trnsl_sts_o;
  logic [7:0]   trnsl_zpd_cnt_o;
  logic         trnsl_zpd_update_o;
  logic         trnsl_allow_access_o;
  logic         trnsl_err_o;

  int errors = 0;
  int checks = 0;
  logic [511:0] line_a, line_b;
  logic [76:0]  pkt;
  logic [76:0]  exp_pkt;

  assign pkt = {trnsl_err_o, trnsl_allow_access_o, trnsl_zpd_update_o, trnsl_sts_o, trnsl_zpd_cnt_o, trnsl_ppa_o};

  always #5 clk_i = ~clk_i;

  hawk_att_lookup dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lkup_valid_i(lkup_valid_i), .lkup_ready_o(lkup_ready_o),
    .lkup_hppa_i(lkup_hppa_i), .lkup_zeroblkwr_i(lkup_zeroblkwr_i),
    .att_inval_i(att_inval_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .trnsl_valid_o(trnsl_valid_o), .trnsl_ready_i(trnsl_ready_i),
    .trnsl_ppa_o(trnsl_ppa_o), .trnsl_sts_o(trnsl_sts_o), .trnsl_zpd_cnt_o(trnsl_zpd_cnt_o),
    .trnsl_zpd_update_o(trnsl_zpd_update_o), .trnsl_allow_access_o(trnsl_allow_access_o),
    .trnsl_err_o(trnsl_err_o)
  );

  function automatic logic [63:0] mk(input logic [7:0] z, input logic [53:0] w, input logic [1:0] s);
    return {z, w, s};
  endfunction

  // Memory holds entries byte-reversed per 8-byte lane.
  function automatic logic [63:0] sw(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = x[8*(7-b) +: 8];
    return r;
  endfunction

  function automatic logic [76:0] ep(input logic e, input logic a, input logic u, input logic [1:0] s,
                                     input logic [7:0] z, input logic [63:0] p);
    return {e, a, u, s, z, p};
  endfunction

  task automatic accept(input logic [51:0] h, input logic z);
    lkup_hppa_i = h; lkup_zeroblkwr_i = z; lkup_valid_i = 1'b1;
    @(posedge clk_i); #1;
    lkup_valid_i = 1'b0;
  endtask

  task automatic ar_hs();
    arready_i = 1'b1;
    @(posedge clk_i); #1;
    arready_i = 1'b0;
  endtask

  task automatic r_beat(input logic [511:0] d, input logic [1:0] rs, input logic lst, input logic inv);
    rvalid_i = 1'b1; rdata_i = d; rresp_i = rs; rlast_i = lst; att_inval_i = inv;
    @(posedge clk_i); #1;
    rvalid_i = 1'b0; rresp_i = '0; rlast_i = 1'b0; att_inval_i = 1'b0;
  endtask

  task automatic t_hs();
    trnsl_ready_i = 1'b1;
    @(posedge clk_i); #1;
    trnsl_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    checks++; if (lkup_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", lkup_ready_o); end
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%b exp=0", arvalid_o); end
    checks++; if (rready_o !== 1'b0) begin errors++; $display("FAIL rst_rready got=%b exp=0", rready_o); end
    checks++; if (trnsl_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0", trnsl_valid_o); end
    checks++; if (pkt !== '0) begin errors++; $display("FAIL rst_payload got=%h exp=0", pkt); end
  endtask

  task automatic test_miss();
    accept(BASE + 52'd9, 1'b0);
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL miss_arvalid got=%b exp=1", arvalid_o); end
    checks++; if (araddr_o !== 64'hFFF6100040) begin errors++; $display("FAIL miss_araddr got=%h exp=fff6100040", araddr_o); end
    checks++; if (arlen_o !== 8'd0) begin errors++; $display("FAIL miss_arlen got=%h exp=0", arlen_o); end
    checks++; if (lkup_ready_o !== 1'b0) begin errors++; $display("FAIL miss_ready got=%b exp=0", lkup_ready_o); end
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if ({arvalid_o, araddr_o} !== {1'b1, 64'hFFF6100040}) begin errors++; $display("FAIL miss_ar_hold got=%b/%h exp=1/fff6100040", arvalid_o, araddr_o); end
    ar_hs();
    checks++; if ({rready_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL miss_rready got=%b exp=10", {rready_o, arvalid_o}); end
    r_beat(line_a, 2'b00, 1'b1, 1'b0);
    exp_pkt = ep(1'b0, 1'b1, 1'b0, 2'b01, 8'd3, 64'h1234000);
    checks++; if (trnsl_valid_o !== 1'b1) begin errors++; $display("FAIL miss_tvalid got=%b exp=1", trnsl_valid_o); end
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL miss_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  task automatic test_hit();
    accept(BASE + 52'd10, 1'b0);
    exp_pkt = ep(1'b0, 1'b1, 1'b0, 2'b01, 8'd7, 64'h5678000);
    checks++; if ({trnsl_valid_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL hit_valid got=%b exp=10", {trnsl_valid_o, arvalid_o}); end
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL hit_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  task automatic test_inval();
    att_inval_i = 1'b1;
    @(posedge clk_i); #1;
    att_inval_i = 1'b0;
    accept(BASE + 52'd10, 1'b0);
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL inval_arvalid got=%b exp=1", arvalid_o); end
    ar_hs();
    // invalidate on the same cycle as the fill: data used now, not retained
    r_beat(line_a, 2'b00, 1'b1, 1'b1);
    exp_pkt = ep(1'b0, 1'b1, 1'b0, 2'b01, 8'd7, 64'h5678000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL inval_fill_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd9, 1'b0);
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL inval_race_arvalid got=%b exp=1", arvalid_o); end
    ar_hs();
    r_beat(line_a, 2'b00, 1'b1, 1'b0);
    t_hs();
    accept(BASE + 52'd10, 1'b0);
    checks++; if ({trnsl_valid_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL refill_hit got=%b exp=10", {trnsl_valid_o, arvalid_o}); end
    t_hs();
  endtask

  task automatic test_zpd();
    accept(BASE + 52'd17, 1'b1);
    checks++; if (araddr_o !== 64'hFFF6100080) begin errors++; $display("FAIL zpd_araddr got=%h exp=fff6100080", araddr_o); end
    ar_hs();
    r_beat(line_b, 2'b00, 1'b1, 1'b0);
    exp_pkt = ep(1'b0, 1'b1, 1'b1, 2'b01, 8'd255, 64'h42000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL zpd_sat got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd18, 1'b1);
    exp_pkt = ep(1'b0, 1'b0, 1'b0, 2'b10, 8'd5, 64'h77000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL zpd_comp got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd19, 1'b1);
    exp_pkt = ep(1'b0, 1'b1, 1'b1, 2'b01, 8'd10, 64'h99000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL zpd_inc got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd19, 1'b0);
    exp_pkt = ep(1'b0, 1'b1, 1'b0, 2'b01, 8'd9, 64'h99000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL zpd_nowr got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  task automatic test_axi_err();
    exp_pkt = ep(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 64'h0);
    accept(BASE + 52'd33, 1'b1);
    checks++; if (araddr_o !== 64'hFFF6100100) begin errors++; $display("FAIL err_araddr got=%h exp=fff6100100", araddr_o); end
    ar_hs();
    r_beat(line_b, 2'b10, 1'b1, 1'b0);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL err_rresp got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd33, 1'b1);
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL err_nofill got=%b exp=1", arvalid_o); end
    ar_hs();
    r_beat(line_b, 2'b00, 1'b0, 1'b0);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL err_rlast got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd33, 1'b0);
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL err_rlast_nofill got=%b exp=1", arvalid_o); end
    ar_hs();
    r_beat(line_b, 2'b00, 1'b1, 1'b0);
    exp_pkt = ep(1'b0, 1'b1, 1'b0, 2'b01, 8'd255, 64'h42000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL err_retry got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  task automatic test_range();
    exp_pkt = ep(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 64'h0);
    accept(BASE - 52'd1, 1'b0);
    checks++; if ({trnsl_valid_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL below_valid got=%b exp=10", {trnsl_valid_o, arvalid_o}); end
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL below_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd524288, 1'b0);
    checks++; if ({trnsl_valid_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL above_valid got=%b exp=10", {trnsl_valid_o, arvalid_o}); end
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL above_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
    accept(BASE + 52'd524287, 1'b0);
    checks++; if ({arvalid_o, araddr_o} !== {1'b1, 64'hFFF64FFFC0}) begin errors++; $display("FAIL last_ar got=%b/%h exp=1/fff64fffc0", arvalid_o, araddr_o); end
    ar_hs();
    r_beat(line_a, 2'b00, 1'b1, 1'b0);
    exp_pkt = ep(1'b0, 1'b0, 1'b0, 2'b10, 8'd0, 64'hA7000);
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL last_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  task automatic test_back_to_back();
    accept(BASE + 52'd524286, 1'b0);
    exp_pkt = ep(1'b0, 1'b0, 1'b0, 2'b10, 8'd0, 64'hA6000);
    for (int c = 0; c < 5; c++) begin
      checks++; if ({trnsl_valid_o, lkup_ready_o} !== 2'b10) begin errors++; $display("FAIL bp_hold c=%0d got=%b exp=10", c, {trnsl_valid_o, lkup_ready_o}); end
      checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL bp_pkt c=%0d got=%h exp=%h", c, pkt, exp_pkt); end
      @(posedge clk_i); #1;
    end
    t_hs();
    checks++; if ({trnsl_valid_o, lkup_ready_o} !== 2'b01) begin errors++; $display("FAIL b2b_idle got=%b exp=01", {trnsl_valid_o, lkup_ready_o}); end
    accept(BASE + 52'd524287, 1'b0);
    exp_pkt = ep(1'b0, 1'b0, 1'b0, 2'b10, 8'd0, 64'hA7000);
    checks++; if ({trnsl_valid_o, arvalid_o} !== 2'b10) begin errors++; $display("FAIL b2b_valid got=%b exp=10", {trnsl_valid_o, arvalid_o}); end
    checks++; if (pkt !== exp_pkt) begin errors++; $display("FAIL b2b_pkt got=%h exp=%h", pkt, exp_pkt); end
    t_hs();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      line_a[64*i +: 64] = sw(mk(8'h00, 54'(160 + i), 2'b10));
      line_b[64*i +: 64] = sw(mk(8'h00, 54'(176 + i), 2'b00));
    end
    line_a[64*1 +: 64] = sw(mk(8'd3, 54'h1234, 2'b01));
    line_a[64*2 +: 64] = sw(mk(8'd7, 54'h5678, 2'b01));
    line_b[64*1 +: 64] = sw(mk(8'd255, 54'h42, 2'b01));
    line_b[64*2 +: 64] = sw(mk(8'd5, 54'h77, 2'b10));
    line_b[64*3 +: 64] = sw(mk(8'd9, 54'h99, 2'b01));
    test_reset();
    test_miss();
    test_hit();
    test_inval();
    test_zpd();
    test_axi_err();
    test_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
